wb_mem_responder: RTL and testbench

Synthesizable Wishbone B3 classic-cycle slave: a word-addressed memory behind a programmable number of wait states, with error responses for bad addresses and optional periodic retry responses. It is the responder counterpart to the testbench Wishbone driver. It is used as a bus target for self-checking driver regressions and as a memory-mapped scratch target beside the quad UART on the shared Wishbone bus.

---
 rtl/wb_mem_responder.sv | 184 ++++++++++++++++++
 tb/tb_wb_mem_responder.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_mem_responder.sv
// Wishbone B3 classic-cycle slave: word-addressed memory behind a fixed
// number of wait states. Bad addresses terminate with err; every
// RETRY_EVERY-th in-range access terminates with rty when enabled.
module wb_mem_responder #(
  parameter logic [31:0] ADDR_BASE   = 32'h0000_1000,
  parameter int          DEPTH_LOG2  = 6,
  parameter int          WAIT_STATES = 2,
  parameter int          RETRY_EVERY = 0
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_i,
  input  logic [31:0] wb_adr_i,
  input  logic [31:0] wb_dat_i,
  output logic [31:0] wb_dat_o,
  input  logic        wb_we_i,
  input  logic [3:0]  wb_sel_i,
  input  logic        wb_stb_i,
  input  logic        wb_cyc_i,
  output logic        wb_ack_o,
  output logic        wb_err_o,
  output logic        wb_rty_o
);

  localparam int          DEPTH      = 1 << DEPTH_LOG2;
  localparam logic [32:0] ADDR_END   = {1'b0, ADDR_BASE} + (33'd4 << DEPTH_LOG2);
  localparam logic [3:0]  WAIT_LOAD  = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;
  localparam logic [15:0] RETRY_LAST = (RETRY_EVERY > 0) ? 16'(RETRY_EVERY - 1) : 16'd0;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t state, state_next;

  // Request captured in IDLE; later input changes are ignored.
  logic [31:0] adr_q;
  logic [31:0] wdata_q;
  logic        we_q;
  logic [3:0]  sel_q;

  logic [3:0]  wait_cnt;
  logic [15:0] retry_cnt;

  logic        ack_q, err_q, rty_q;
  logic [31:0] rdata_q;

  logic [31:0] mem [0:DEPTH-1];

  logic        req;
  logic        enter_resp;
  logic [31:0] cur_adr;
  logic [31:0] cur_dat;
  logic        cur_we;
  logic [3:0]  cur_sel;
  logic        in_range;
  logic        retry_hit;
  logic [DEPTH_LOG2-1:0] index;

  logic        resp_ack, resp_err, resp_rty;
  logic        mem_wr;

  assign req = wb_cyc_i & wb_stb_i;

  // Select the request being decoded: live inputs when a zero-wait access
  // is accepted straight out of IDLE, the captured request otherwise.
  always_comb begin
    // NOTE: every always_comb output gets a default before any branch so
    // no path leaves it unassigned and no latch is inferred.
    cur_adr = adr_q;
    cur_dat = wdata_q;
    cur_we  = we_q;
    cur_sel = sel_q;
    if (state == S_IDLE) begin
      cur_adr = wb_adr_i;
      cur_dat = wb_dat_i;
      cur_we  = wb_we_i;
      cur_sel = wb_sel_i;
    end
  end

  // Address decode; 33-bit compares keep the end bound from wrapping.
  assign in_range = ({1'b0, cur_adr} >= {1'b0, ADDR_BASE}) &&
                    ({1'b0, cur_adr} <  ADDR_END) &&
                    (cur_adr[1:0] == 2'b00);
  // Base is word aligned, so the low index bits of the difference only
  // depend on the low address bits.
  assign index     = cur_adr[DEPTH_LOG2+1:2] - ADDR_BASE[DEPTH_LOG2+1:2];
  assign retry_hit = (RETRY_EVERY > 0) && (retry_cnt == RETRY_LAST);

  // State register.
  always_ff @(posedge wb_clk_i) begin
    // NOTE: clocked state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    if (!wb_rst_i) state <= S_IDLE;
    else           state <= state_next;
  end

  // Next-state logic; a dropped cycle in WAIT aborts silently.
  always_comb begin
    state_next = state;
    case (state)
      S_IDLE: if (req) state_next = (WAIT_STATES == 0) ? S_RESP : S_WAIT;
      S_WAIT: begin
        if (!wb_cyc_i)          state_next = S_IDLE;
        else if (wait_cnt == 0) state_next = S_RESP;
      end
      S_RESP:  state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  assign enter_resp = (state != S_RESP) && (state_next == S_RESP);

  // Response decision taken on the edge entering RESP: err beats rty beats ack.
  always_comb begin
    resp_ack = 1'b0;
    resp_err = 1'b0;
    resp_rty = 1'b0;
    mem_wr   = 1'b0;
    if (enter_resp && wb_rst_i) begin
      if (!in_range)     resp_err = 1'b1;
      else if (retry_hit) resp_rty = 1'b1;
      else begin
        resp_ack = 1'b1;
        mem_wr   = cur_we;
      end
    end
  end

  // Request capture, wait/retry counters and registered response outputs.
  always_ff @(posedge wb_clk_i) begin
    if (!wb_rst_i) begin
      adr_q     <= '0;
      wdata_q   <= '0;
      we_q      <= 1'b0;
      sel_q     <= '0;
      wait_cnt  <= '0;
      retry_cnt <= '0;
      ack_q     <= 1'b0;
      err_q     <= 1'b0;
      rty_q     <= 1'b0;
      rdata_q   <= '0;
    end else begin
      if (state == S_IDLE && req) begin
        adr_q    <= wb_adr_i;
        wdata_q  <= wb_dat_i;
        we_q     <= wb_we_i;
        sel_q    <= wb_sel_i;
        wait_cnt <= WAIT_LOAD;
      end else if (state == S_WAIT && wait_cnt != 4'd0) begin
        wait_cnt <= wait_cnt - 4'd1;
      end

      if (resp_rty)
        retry_cnt <= '0;
      else if (enter_resp && in_range && RETRY_EVERY > 0)
        retry_cnt <= retry_cnt + 16'd1;

      ack_q   <= resp_ack;
      err_q   <= resp_err;
      rty_q   <= resp_rty;
      rdata_q <= (resp_ack && !cur_we) ? mem[index] : '0;
    end
  end

  // Byte-lane write, committed on the edge entering an acked RESP.
  always_ff @(posedge wb_clk_i) begin
    // NOTE: the storage array has no reset; clearing it would turn the RAM
    // into a flop bank and its contents are defined only after a write.
    if (mem_wr) begin
      for (int b = 0; b < 4; b++) begin
        if (cur_sel[b]) mem[index][8*b +: 8] <= cur_dat[8*b +: 8];
      end
    end
  end

  assign wb_ack_o = ack_q;
  assign wb_err_o = err_q;
  assign wb_rty_o = rty_q;
  assign wb_dat_o = rdata_q;

endmodule

// File: tb/tb_wb_mem_responder.sv
// Self-checking bench for wb_mem_responder: one instance without retries and
// one with RETRY_EVERY = 3 share the same bus stimulus. Expected responses are
// queued when a request is sampled and popped when the response appears.
module tb_wb_mem_responder;

  localparam int WS = 2;

  localparam logic [1:0] K_NONE = 2'd0;
  localparam logic [1:0] K_ACK  = 2'd1;
  localparam logic [1:0] K_ERR  = 2'd2;
  localparam logic [1:0] K_RTY  = 2'd3;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] adr, dat_w;
  logic        we, stb, cyc;
  logic [3:0]  sel;

  logic [31:0] dat_r;
  logic        ack, err, rty;
  logic [31:0] r_dat;
  logic        r_ack, r_err, r_rty;

  wb_mem_responder #(
    .ADDR_BASE(32'h0000_1000), .DEPTH_LOG2(6), .WAIT_STATES(WS), .RETRY_EVERY(0)
  ) u_dut (
    .wb_clk_i(clk), .wb_rst_i(rst_n), .wb_adr_i(adr), .wb_dat_i(dat_w),
    .wb_dat_o(dat_r), .wb_we_i(we), .wb_sel_i(sel), .wb_stb_i(stb),
    .wb_cyc_i(cyc), .wb_ack_o(ack), .wb_err_o(err), .wb_rty_o(rty)
  );

  wb_mem_responder #(
    .ADDR_BASE(32'h0000_1000), .DEPTH_LOG2(6), .WAIT_STATES(WS), .RETRY_EVERY(3)
  ) u_rty (
    .wb_clk_i(clk), .wb_rst_i(rst_n), .wb_adr_i(adr), .wb_dat_i(dat_w),
    .wb_dat_o(r_dat), .wb_we_i(we), .wb_sel_i(sel), .wb_stb_i(stb),
    .wb_cyc_i(cyc), .wb_ack_o(r_ack), .wb_err_o(r_err), .wb_rty_o(r_rty)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  kind;
    logic [31:0] data;
    bit          dv;    // data is known and must match
    int          cyc;
  } exp_t;

  exp_t q_main[$];
  exp_t q_rty[$];

  logic [31:0] mem_m [logic [31:0]];
  logic [31:0] mem_r [logic [31:0]];
  int rty_cnt_m = 0;

  int n_checks = 0;
  int n_errors = 0;
  int cyc_cnt  = 0;
  int resp_seen = 0;
  int exp_resp  = 0;
  int viol      = 0;
  bit mon_en    = 1'b0;

  logic [31:0] rd;
  logic [1:0]  rk;

  always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

  // Protocol monitor on the no-retry instance: count terminations, flag
  // multiple terminations or read data outside ack.
  always @(negedge clk) begin
    if (mon_en) begin
      if (ack === 1'b1 || err === 1'b1 || rty === 1'b1) resp_seen++;
      if ((int'(ack === 1'b1) + int'(err === 1'b1) + int'(rty === 1'b1)) > 1) viol++;
      if (ack !== 1'b1 && dat_r !== 32'h0) viol++;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic bit in_range_m(input logic [31:0] a);
    return (a >= 32'h1000) && (a < 32'h1100) && (a[1:0] == 2'b00);
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d,
                                        input logic [3:0] s);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++) if (s[b]) r[8*b +: 8] = d[8*b +: 8];
    return r;
  endfunction

  function automatic logic [1:0] kind_of(input logic a, input logic e, input logic r);
    if (a === 1'b1) return K_ACK;
    if (e === 1'b1) return K_ERR;
    if (r === 1'b1) return K_RTY;
    return K_NONE;
  endfunction

  // One complete classic cycle. Returns read data and the retry-instance kind.
  task automatic xfer(input logic [31:0] a, input logic w, input logic [3:0] s,
                      input logic [31:0] d, output logic [31:0] rdat,
                      output logic [1:0] rkind);
    exp_t e, er;
    bit got;
    @(negedge clk);
    adr = a; we = w; sel = s; dat_w = d; cyc = 1'b1; stb = 1'b1;
    @(posedge clk);
    #1;
    // Scramble request inputs during WAIT; they must be ignored.
    adr = 32'hFFFF_FFF0; dat_w = ~d; sel = ~s; we = ~w;

    e.cyc = cyc_cnt + WS; e.data = 32'h0; e.dv = 1'b1;
    er.cyc = e.cyc;       er.data = 32'h0; er.dv = 1'b1;
    if (!in_range_m(a)) begin
      e.kind  = K_ERR;
      er.kind = K_ERR;
    end else begin
      e.kind = K_ACK;
      if (!w) begin
        e.dv = mem_m.exists(a);
        if (e.dv) e.data = mem_m[a];
      end else if (s == 4'hF) mem_m[a] = d;
      else if (mem_m.exists(a)) mem_m[a] = merge(mem_m[a], d, s);

      if (rty_cnt_m == 2) begin
        er.kind = K_RTY;
        rty_cnt_m = 0;
      end else begin
        er.kind = K_ACK;
        rty_cnt_m++;
        if (!w) begin
          er.dv = mem_r.exists(a);
          if (er.dv) er.data = mem_r[a];
        end else if (s == 4'hF) mem_r[a] = d;
        else if (mem_r.exists(a)) mem_r[a] = merge(mem_r[a], d, s);
      end
    end
    q_main.push_back(e);
    q_rty.push_back(er);
    exp_resp++;

    got = 1'b0;
    for (int n = 0; n < 20; n++) begin
      @(negedge clk);
      if (ack === 1'b1 || err === 1'b1 || rty === 1'b1) begin
        got = 1'b1;
        break;
      end
    end
    rdat  = dat_r;
    rkind = kind_of(r_ack, r_err, r_rty);
    if (!got) begin
      check("timeout", 32'd0, 32'd1);
      void'(q_main.pop_front());
      void'(q_rty.pop_front());
    end else begin
      e  = q_main.pop_front();
      er = q_rty.pop_front();
      check("kind", 32'(kind_of(ack, err, rty)), 32'(e.kind));
      if (e.dv) check("data", dat_r, e.data);
      check("latency", 32'(cyc_cnt), 32'(e.cyc));
      check("rty_kind", 32'(rkind), 32'(er.kind));
      if (er.dv) check("rty_data", r_dat, er.data);
    end
    cyc = 1'b0; stb = 1'b0;
  endtask

  // Write accepted, then cycle dropped in the first WAIT cycle.
  task automatic abort_write(input logic [31:0] a, input logic [31:0] d);
    @(negedge clk);
    adr = a; we = 1'b1; sel = 4'hF; dat_w = d; cyc = 1'b1; stb = 1'b1;
    @(posedge clk);
    @(negedge clk);
    cyc = 1'b0; stb = 1'b0;
    repeat (5) @(negedge clk);
  endtask

  // Read accepted, then reset asserted while in WAIT.
  task automatic reset_in_wait(input logic [31:0] a);
    @(negedge clk);
    adr = a; we = 1'b0; sel = 4'hF; cyc = 1'b1; stb = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    check("rst_wait_out", {29'd0, ack, err, rty}, 32'd0);
    rst_n = 1'b1; cyc = 1'b0; stb = 1'b0;
    rty_cnt_m = 0;
    repeat (5) @(negedge clk);
  endtask

  task automatic reset_pulse();
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    rty_cnt_m = 0;
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got stuck expected finish");
    $fatal(1, "simulation time limit");
  end

  initial begin
    rst_n = 1'b0; adr = 32'h1000; dat_w = 32'h0; we = 1'b0; sel = 4'hF;
    cyc = 1'b1; stb = 1'b1;

    // Reset held with a live strobe: no termination, no data.
    repeat (3) begin
      @(negedge clk);
      mon_en = 1'b1;
      check("rst_flags", {29'd0, ack, err, rty}, 32'd0);
      check("rst_dat", dat_r, 32'd0);
    end
    cyc = 1'b0; stb = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);

    // Basic write / read.
    xfer(32'h1000, 1'b1, 4'hF, 32'hDEAD_BEEF, rd, rk);
    xfer(32'h1000, 1'b0, 4'hF, 32'h0, rd, rk);
    check("rd_1000", rd, 32'hDEAD_BEEF);

    // Byte lanes, including an all-lanes-off write.
    xfer(32'h1004, 1'b1, 4'hF, 32'hAABB_CCDD, rd, rk);
    xfer(32'h1004, 1'b1, 4'h5, 32'h1122_3344, rd, rk);
    xfer(32'h1004, 1'b1, 4'h0, 32'h5555_5555, rd, rk);
    xfer(32'h1004, 1'b0, 4'h0, 32'h0, rd, rk);
    check("rd_lanes", rd, 32'hAA22_CC44);

    // Address errors leave memory intact.
    xfer(32'h10FC, 1'b1, 4'hF, 32'h5A5A_5A5A, rd, rk);
    xfer(32'h1100, 1'b1, 4'hF, 32'hFFFF_FFFF, rd, rk);
    xfer(32'h0FFC, 1'b0, 4'hF, 32'h0, rd, rk);
    check("err_dat", rd, 32'h0);
    xfer(32'h1002, 1'b0, 4'hF, 32'h0, rd, rk);
    xfer(32'h10FC, 1'b0, 4'hF, 32'h0, rd, rk);
    check("rd_10fc", rd, 32'h5A5A_5A5A);

    // Aborted write does not commit.
    xfer(32'h1008, 1'b1, 4'hF, 32'h1234_5678, rd, rk);
    abort_write(32'h1008, 32'hCAFE_F00D);
    xfer(32'h1008, 1'b0, 4'hF, 32'h0, rd, rk);
    check("rd_abort", rd, 32'h1234_5678);

    // Reset during WAIT, then a clean transaction.
    reset_in_wait(32'h1000);
    xfer(32'h1000, 1'b0, 4'hF, 32'h0, rd, rk);
    check("rd_after_rst", rd, 32'hDEAD_BEEF);

    // Retry sequence on the RETRY_EVERY = 3 instance.
    reset_pulse();
    xfer(32'h1000, 1'b0, 4'hF, 32'h0, rd, rk);
    check("rty_seq0", 32'(rk), 32'(K_ACK));
    xfer(32'h2000, 1'b0, 4'hF, 32'h0, rd, rk);
    check("rty_seq_err", 32'(rk), 32'(K_ERR));
    xfer(32'h1004, 1'b0, 4'hF, 32'h0, rd, rk);
    check("rty_seq1", 32'(rk), 32'(K_ACK));
    xfer(32'h1008, 1'b0, 4'hF, 32'h0, rd, rk);
    check("rty_seq2", 32'(rk), 32'(K_RTY));
    xfer(32'h1000, 1'b0, 4'hF, 32'h0, rd, rk);
    check("rty_seq3", 32'(rk), 32'(K_ACK));

    repeat (4) @(negedge clk);
    check("resp_count", 32'(resp_seen), 32'(exp_resp));
    check("protocol", 32'(viol), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
